// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    // Control states of the multiplier sequencer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Widest operand supported; helpers work at this width and callers truncate.
    localparam int MAX_W = 32;

    // Magnitude of a sign-extended operand. The most negative WIDTH-bit value
    // comes out as 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                                   input logic             sign_en);
        if (sign_en && value[MAX_W-1]) begin
            return (~value) + MAX_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Shift-add datapath: accumulator, shifting multiplicand and shifting multiplier.
module seq_mul_datapath #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_mag_a,
    input  logic [WIDTH-1:0]     i_mag_b,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mag_b;

    // Load operands on accept, then consume one multiplier bit per step.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mag_b <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, i_mag_a};
            r_mag_b <= i_mag_b;
        end else if (i_step) begin
            if (r_mag_b[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mag_b <= r_mag_b >> 1;
            r_mcand <= r_mcand << 1;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier with signed/unsigned mode and start/busy/done
// handshake. Fixed latency: WIDTH CALC cycles plus one FINISH cycle.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [MAX_W-1:0]     w_a_ext;
    logic [MAX_W-1:0]     w_b_ext;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_load;
    logic                 w_step;
    logic [2*WIDTH-1:0]   w_acc;

    // Operands are sign-extended only in signed mode, so the magnitude helper
    // leaves unsigned operands untouched.
    assign w_a_ext = is_signed ? MAX_W'($signed(a)) : MAX_W'(a);
    assign w_b_ext = is_signed ? MAX_W'($signed(b)) : MAX_W'(b);
    assign w_mag_a = WIDTH'(abs_val(w_a_ext, is_signed));
    assign w_mag_b = WIDTH'(abs_val(w_b_ext, is_signed));

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == CALC);

    seq_mul_datapath #(
        .WIDTH   (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_mag_a (w_mag_a),
        .i_mag_b (w_mag_b),
        .o_acc   (w_acc)
    );

    // Sequencer: accept in IDLE, count WIDTH steps in CALC, publish in FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    // Negating zero yields zero, so no -0 can appear.
                    r_product <= r_neg ? ((~w_acc) + PROD_ONE) : w_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: three instances (WIDTH 4, 8, 16) sharing one
// clock and reset, a per-instance scoreboard queue and directed scenario tasks.
module tb_seq_mul;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  sgn;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [31:0] a_in [3];
    logic [31:0] b_in [3];
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .is_signed(sgn[0]),
        .a(a_in[0][3:0]), .b(b_in[0][3:0]),
        .busy(busy[0]), .done(done[0]), .product(p4)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start[1]), .is_signed(sgn[1]),
        .a(a_in[1][7:0]), .b(b_in[1][7:0]),
        .busy(busy[1]), .done(done[1]), .product(p8)
    );

    seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start[2]), .is_signed(sgn[2]),
        .a(a_in[2][15:0]), .b(b_in[2][15:0]),
        .busy(busy[2]), .done(done[2]), .product(p16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wof(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 16);
    endfunction

    function automatic logic [63:0] prod_of(input int k);
        case (k)
            0:       return {56'd0, p4};
            1:       return {48'd0, p8};
            default: return {32'd0, p16};
        endcase
    endfunction

    // Reference: interpret operands at width w, multiply in 64 bits, keep 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [31:0] m;
        longint      xv;
        longint      yv;
        logic [63:0] r;
        m  = (32'd1 << w) - 32'd1;
        xv = longint'(x & m);
        yv = longint'(y & m);
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        r = 64'(xv * yv);
        r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    function automatic void push_exp(input int k, input logic [63:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Scoreboard: every done pulse pops the oldest expectation of its unit.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k]) begin
                logic [63:0] e;
                total++;
                if (q_size(k) == 0) begin
                    bad++;
                    $display("FAIL unexpected_done unit=%0d got=%h", k, prod_of(k));
                end else begin
                    case (k)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    if (prod_of(k) !== e) begin
                        bad++;
                        $display("FAIL product unit=%0d got=%h exp=%h", k, prod_of(k), e);
                    end
                end
            end
        end
    end

    // Wait for the unit to be idle, present one operation, and record its result.
    task automatic issue(input int k, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy[k]) begin
            total++;
            bad++;
            $display("FAIL issue_timeout unit=%0d got=busy exp=idle", k);
            return;
        end
        start[k] = 1'b1;
        sgn[k]   = s;
        a_in[k]  = x;
        b_in[k]  = y;
        push_exp(k, e);
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size() != 0 || busy != 3'b000) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q0.size() + q1.size() + q2.size() != 0 || busy != 3'b000) begin
            bad++;
            $display("FAIL drain_timeout got=pending:%0d/%0d/%0d exp=0/0/0",
                     q0.size(), q1.size(), q2.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy[k] !== 1'b0 || done[k] !== 1'b0 || prod_of(k) !== 64'd0) begin
                bad++;
                $display("FAIL reset_state unit=%0d got=busy%b done%b prod%h exp=0/0/0",
                         k, busy[k], done[k], prod_of(k));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 3 * -2 at WIDTH 4: busy for 5 cycles, done in the 6th cycle after accept.
    task automatic test_latency();
        int dcyc;
        int nbusy;
        dcyc  = 0;
        nbusy = 0;
        @(negedge clk);
        start[0] = 1'b1;
        sgn[0]   = 1'b1;
        a_in[0]  = 32'h3;
        b_in[0]  = 32'hE;
        push_exp(0, 64'hFA);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start[0] = 1'b0;
                a_in[0]  = 32'h7;
                b_in[0]  = 32'h7;
            end
            if (busy[0]) nbusy++;
            if (done[0] && dcyc == 0) dcyc = c;
        end
        total++;
        if (dcyc !== 6) begin
            bad++;
            $display("FAIL done_latency got=%0d exp=6", dcyc);
        end
        total++;
        if (nbusy !== 5) begin
            bad++;
            $display("FAIL busy_cycles got=%0d exp=5", nbusy);
        end
        total++;
        if (p4 !== 8'hFA) begin
            bad++;
            $display("FAIL product_hold got=%h exp=fa", p4);
        end
    endtask

    task automatic test_corners();
        issue(0, 1'b1, 32'h8,  32'h8,  64'h40);
        issue(0, 1'b0, 32'hF,  32'hF,  64'hE1);
        issue(1, 1'b1, 32'h80, 32'h7F, 64'hC080);
        issue(0, 1'b1, 32'h0,  32'h9,  64'h0);
        issue(1, 1'b0, 32'h0,  32'hFF, 64'h0);
        issue(1, 1'b1, 32'h0,  32'h80, 64'h0);
        issue(2, 1'b1, 32'hFFFF, 32'h8000, 64'h8000);
        issue(2, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001);
        wait_idle();
    endtask

    // start held high with fresh operands every cycle: one result per 6 cycles.
    task automatic test_back_to_back();
        int dt[$];
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done[0]) dt.push_back(i);
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            s = 1'($urandom_range(0, 1));
            start[0] = 1'b1;
            sgn[0]   = s;
            a_in[0]  = x;
            b_in[0]  = y;
            if (!busy[0]) push_exp(0, ref_mul(4, s, x, y));
        end
        @(negedge clk);
        start[0] = 1'b0;
        total++;
        if (dt.size() < 5) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=>=5", dt.size());
        end
        for (int i = 1; i < dt.size(); i++) begin
            total++;
            if (dt[i] - dt[i-1] !== 6) begin
                bad++;
                $display("FAIL b2b_interval got=%0d exp=6", dt[i] - dt[i-1]);
            end
        end
        wait_idle();
    endtask

    // Asynchronous reset pulse in the middle of CALC discards the operation.
    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        issue(0, 1'b1, 32'h5, 32'h3, 64'h0F);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || p4 !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=busy%b done%b prod%h exp=0/0/00", busy[0], done[0], p4);
        end
        total++;
        if (p8 !== 16'h0 || p16 !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_others got=%h/%h exp=0/0", p8, p16);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL reset_no_done got=%0d exp=0", ndone);
        end
        issue(0, 1'b1, 32'h9, 32'h6, 64'hD6);
        wait_idle();
    endtask

    task automatic rand_unit(input int k);
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        int          w;
        w = wof(k);
        for (int i = 0; i < 2000; i++) begin
            x = $urandom() & ((32'd1 << w) - 32'd1);
            y = $urandom() & ((32'd1 << w) - 32'd1);
            s = 1'($urandom_range(0, 1));
            issue(k, s, x, y, ref_mul(w, s, x, y));
        end
    endtask

    task automatic test_random();
        fork
            begin rand_unit(0); end
            begin rand_unit(1); end
            begin rand_unit(2); end
        join
        wait_idle();
    endtask

    initial begin
        rst   = 1'b1;
        start = 3'b000;
        sgn   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
Parametrised sequential shift-add multiplier. It generalises the team's 4-bit signed multiplier to WIDTH-bit operands and adds a signed/unsigned mode select, a start/busy/done handshake and an asynchronous reset. It accepts one operation at a time and iterates one multiplier bit per clock. It sits as a multi-cycle functional unit beside the ALU in the experiment datapath.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with start
a  input  WIDTH  multiplicand; latched with start
b  input  WIDTH  multiplier; latched with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; product valid and newly updated
product  output  2*WIDTH  result; held until the next completion

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state returns to IDLE; busy=0, done=0, product=0.
  - All internal registers are cleared; the in-flight operation is discarded and never produces done.
- IDLE:
  - If start=1 on a clock edge, latch the operands and set busy=1, then go to CALC.
  - Operand latching: mag_a = |a| and mag_b = |b| when is_signed=1, else raw a and b.
  - neg = is_signed & (a[W-1] ^ b[W-1]).
  - acc = 0; mcand = zero-extended mag_a (2*WIDTH bits); cnt = 0.
  - If start=0, stay in IDLE.
- Magnitude rule: the magnitude of the most negative value (-2^(W-1)) is represented as unsigned 2^(W-1) in WIDTH bits. No overflow is possible: the full product always fits in 2*WIDTH bits.
- CALC, one multiplier bit per cycle:
  - If mag_b[0], then acc += mcand.
  - mag_b >>= 1; mcand <<= 1; cnt++.
  - Exactly WIDTH cycles; after the cycle with cnt==WIDTH-1, go to FINISH.
  - No early exit on a zero multiplier; latency is fixed.
- FINISH (1 cycle):
  - product <= neg ? (~acc + 1) : acc.
  - done=1 for this cycle only; busy=0 from the next cycle; return to IDLE.
- Latency: start accepted at edge N; done=1 and product valid in the cycle after edge N+WIDTH+1. Total is WIDTH+2 clocks of occupancy; busy is high for WIDTH+1 cycles.
- Back-to-back: start may be asserted in the cycle done is high. It is sampled at the next edge, when the block is in IDLE, so throughput is one result per WIDTH+2 cycles.
- start while busy: ignored, with no queuing. Operand changes while busy have no effect.
- Zero operands are processed normally and give product 0. In signed mode, a negated 0 stays 0, so there is no -0.
- Registered outputs only; no combinational path from inputs to outputs.
- Three states: IDLE, CALC, FINISH. Any undefined state encoding goes to IDLE.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, CALC, FINISH};
  - function abs_val(value, sign_en) returning a WIDTH-bit unsigned magnitude;
  - localparam CNT_W = $clog2(WIDTH+1).
- One natural sub-module, mul_datapath: the acc/mcand/mag_b registers and the adder. The FSM and handshake stay in seq_mul.
- A single module is acceptable at this size.

Test Plan:
- WIDTH=4, signed, a=3, b=-2 (4'b1110) -> done exactly 6 cycles after start is accepted; product=8'hFA (-6); busy high for 5 cycles.
- WIDTH=4, signed, a=-8, b=-8 -> product=8'h40 (64). WIDTH=4, unsigned, a=15, b=15 -> product=8'hE1 (225).
- WIDTH=8, signed, a=-128, b=127 -> product=16'hC080 (-16256). A=0 with any b -> product 0 and done still pulses.
- Assert start=1 continuously with new operands every cycle -> ops complete every WIDTH+2 cycles; mid-operation operand changes do not alter the result in flight.
- Assert rst for 1 cycle, asynchronously, in the middle of CALC -> busy, done and product go to 0 immediately, with no done pulse; the next start completes correctly.
- Random regression: 2000 ops per WIDTH in {4,8,16}, random mode -> product equals the reference multiply, truncated to 2*WIDTH bits.
